// File: rtl/sap1_ctrl_pkg.sv
// sap1_ctrl_pkg: shared SAP-1 control-word layout, opcodes and fetch constants.
package sap1_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = 12'h3E3;
    localparam ctrl_word_t CW_T1   = 12'h5E3;
    localparam ctrl_word_t CW_T2   = 12'hBE3;
    localparam ctrl_word_t CW_T3   = 12'h263;

    function automatic logic op_defined(input logic [3:0] op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational (T-index, opcode) to SAP-1 control word.
// t_idx_i is 1..6 for T1..T6; 0 means no decodable T-state.
module ctrl_decode
    import sap1_ctrl_pkg::*;
(
    input  logic [2:0] t_idx_i,
    input  logic [3:0] opcode_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o = CW_IDLE;
        case (t_idx_i)
            3'd1: cw_o = CW_T1;
            3'd2: cw_o = CW_T2;
            3'd3: cw_o = CW_T3;
            3'd4: cw_o = (opcode_i inside {OP_LDA, OP_ADD, OP_SUB}) ? ctrl_word_t'(12'h1A3) :
                         (opcode_i == OP_OUT) ? ctrl_word_t'(12'h3F2) : CW_IDLE;
            3'd5: cw_o = (opcode_i == OP_LDA) ? ctrl_word_t'(12'h2C3) :
                         (opcode_i inside {OP_ADD, OP_SUB}) ? ctrl_word_t'(12'h2E1) : CW_IDLE;
            3'd6: cw_o = (opcode_i == OP_ADD) ? ctrl_word_t'(12'h3C7) :
                         (opcode_i == OP_SUB) ? ctrl_word_t'(12'h3CF) : CW_IDLE;
            default: cw_o = CW_IDLE;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 control word plus HLT latch, sticky fault flags and
// retired-instruction counter (counter built only when SEQ_INSTR_COUNT_EN is defined).
module control_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter int STATES      = 6,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   CLR_bar,
    input  logic [STATES-1:0]      state,
    input  logic [3:0]             opcode,
    output logic [11:0]            con,
    output logic                   HLT_bar,
    output logic                   ill_op,
    output logic                   t_fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    logic       one_hot;
    logic       bad_state;
    logic       leave_t4;
    logic [2:0] t_idx;
    ctrl_word_t dec_cw;
    logic       halted_q, halted_d;
    logic       ill_q, ill_d;
    logic       tf_q, tf_d;

    assign one_hot   = (state != '0) && ((state & (state - STATES'(1))) == '0);
    assign bad_state = (state != '0) && !one_hot;

    // T7 and above stay at index 0 so they decode as idle
    always_comb begin
        t_idx = 3'd0;
        for (int i = 0; i < 6; i++)
            if (one_hot && state[i]) t_idx = 3'(i + 1);
    end

    ctrl_decode u_dec (
        .t_idx_i  (t_idx),
        .opcode_i (opcode),
        .cw_o     (dec_cw)
    );

    assign leave_t4 = (t_idx == 3'd4);
    assign halted_d = halted_q | (leave_t4 && opcode == OP_HLT);
    assign ill_d    = ill_q | (leave_t4 && !op_defined(opcode));
    assign tf_d     = tf_q | bad_state;

    always_ff @(negedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            halted_q <= 1'b0;
            ill_q    <= 1'b0;
            tf_q     <= 1'b0;
        end else begin
            halted_q <= halted_d;
            ill_q    <= ill_d;
            tf_q     <= tf_d;
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + COUNT_WIDTH'(t_idx == 3'd6 && !halted_q && !tf_q);

    always_ff @(negedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

    assign con     = halted_q ? CW_IDLE : dec_cw;
    assign HLT_bar = ~halted_q;
    assign ill_op  = ill_q;
    assign t_fault = tf_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench against a table-driven
// behavioural model of the SAP-1 control sequencer.
module tb_control_sequencer;

    localparam int SN = 6;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          CLR_bar = 1'b0;
    logic [SN-1:0] state = '0;
    logic [3:0]    opcode = '0;
    logic [11:0]   con;
    logic          HLT_bar, ill_op, t_fault;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int failures = 0;

    logic          m_halted, m_ill, m_tf;
    logic [CW-1:0] m_cnt;

    control_sequencer #(.STATES(SN), .COUNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .CLR_bar     (CLR_bar),
        .state       (state),
        .opcode      (opcode),
        .con         (con),
        .HLT_bar     (HLT_bar),
        .ill_op      (ill_op),
        .t_fault     (t_fault),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] ref_con(input logic [SN-1:0] s, input logic [3:0] op,
                                            input logic halted);
        logic [35:0] row;
        int t;
        if (halted || $countones(s) != 1) return 12'h3E3;
        t = 0;
        for (int i = 0; i < SN; i++) if (s[i]) t = i + 1;
        if (t == 1) return 12'h5E3;
        if (t == 2) return 12'hBE3;
        if (t == 3) return 12'h263;
        if (t > 6) return 12'h3E3;
        case (op)
            4'h0:    row = {12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    row = {12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    row = {12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    row = {12'h3F2, 12'h3E3, 12'h3E3};
            default: row = {3{12'h3E3}};
        endcase
        return row[35 - 12 * (t - 4) -: 12];
    endfunction

    task automatic model_edge(input logic [SN-1:0] s, input logic [3:0] op);
`ifdef SEQ_INSTR_COUNT_EN
        if (s == SN'(32) && !m_halted && !m_tf) m_cnt = m_cnt + 1'b1;
`endif
        if (s != '0 && $countones(s) > 1) m_tf = 1'b1;
        if (s == SN'(8)) begin
            if (op == 4'hF) m_halted = 1'b1;
            else if (!(op inside {4'h0, 4'h1, 4'h2, 4'hE})) m_ill = 1'b1;
        end
    endtask

    task automatic drive(input logic [SN-1:0] s, input logic [3:0] op);
        @(posedge CLK);
        state = s;
        opcode = op;
        #1;
    endtask

    task automatic tick();
        @(negedge CLK);
        model_edge(state, opcode);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        CLR_bar = 1'b0;
        state = '0;
        #2;
        m_halted = 1'b0;
        m_ill = 1'b0;
        m_tf = 1'b0;
        m_cnt = '0;
        CLR_bar = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        logic [11:0] exp;
        for (int k = 0; k < 6; k++) begin
            drive(SN'(1) << k, op);
            exp = ref_con(state, opcode, m_halted);
            checks++;
            if (con !== exp) begin
                failures++;
                $display("FAIL %s con op=%h T%0d got=%h exp=%h", tag, op, k + 1, con, exp);
            end
            tick();
            checks++;
            if ({HLT_bar, ill_op, t_fault, instr_count} !== {~m_halted, m_ill, m_tf, m_cnt}) begin
                failures++;
                $display("FAIL %s flags op=%h T%0d got=%b%b%b/%0d exp=%b%b%b/%0d", tag, op, k + 1,
                         HLT_bar, ill_op, t_fault, instr_count, ~m_halted, m_ill, m_tf, m_cnt);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge CLK);
        CLR_bar = 1'b0;
        state = SN'(8);
        #1;
        checks++;
        if ({HLT_bar, ill_op, t_fault, instr_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b/%0d exp=100/0", HLT_bar, ill_op, t_fault, instr_count);
        end
        state = '0;
        #1;
        checks++;
        if (con !== 12'h3E3) begin
            failures++;
            $display("FAIL reset_con got=%h exp=3e3", con);
        end
        do_reset();
    endtask

    task automatic test_add();
        logic [11:0] exp_seq [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(SN'(1) << k, 4'h1);
            checks++;
            if (con !== exp_seq[k]) begin
                failures++;
                $display("FAIL add_con T%0d got=%h exp=%h", k + 1, con, exp_seq[k]);
            end
            tick();
        end
        checks++;
`ifdef SEQ_INSTR_COUNT_EN
        if (instr_count !== CW'(1)) begin
            failures++;
            $display("FAIL add_count got=%0d exp=1", instr_count);
        end
`else
        if (instr_count !== CW'(0)) begin
            failures++;
            $display("FAIL add_count got=%0d exp=0", instr_count);
        end
`endif
    endtask

    task automatic test_sub_out();
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h0, "lda");
    endtask

    task automatic test_hlt();
        logic [CW-1:0] cnt_before;
        do_reset();
        run_instr(4'h1, "pre_hlt");
        cnt_before = instr_count;
        for (int k = 0; k < 4; k++) begin
            drive(SN'(1) << k, 4'hF);
            if (k < 3) tick();
        end
        checks++;
        if (HLT_bar !== 1'b1 || con !== 12'h3E3) begin
            failures++;
            $display("FAIL hlt_t4 HLT_bar=%b con=%h exp 1/3e3", HLT_bar, con);
        end
        tick();
        drive(SN'(16), 4'hF);
        checks++;
        if (HLT_bar !== 1'b0) begin
            failures++;
            $display("FAIL hlt_t5 HLT_bar=%b exp=0", HLT_bar);
        end
        tick();
        for (int n = 0; n < 8; n++) begin
            drive(SN'(1) << (n % 6), 4'(n));
            checks++;
            if (con !== 12'h3E3) begin
                failures++;
                $display("FAIL hlt_idle n=%0d con=%h exp=3e3", n, con);
            end
            tick();
        end
        checks++;
        if (instr_count !== cnt_before) begin
            failures++;
            $display("FAIL hlt_count got=%0d exp=%0d", instr_count, cnt_before);
        end
        do_reset();
        #1;
        checks++;
        if (HLT_bar !== 1'b1) begin
            failures++;
            $display("FAIL hlt_clear HLT_bar=%b exp=1", HLT_bar);
        end
    endtask

    task automatic test_ill();
        do_reset();
        run_instr(4'h5, "ill");
        checks++;
        if (ill_op !== 1'b1) begin
            failures++;
            $display("FAIL ill_set got=%b exp=1", ill_op);
        end
        run_instr(4'h1, "ill_after");
        checks++;
        if (ill_op !== 1'b1) begin
            failures++;
            $display("FAIL ill_sticky got=%b exp=1", ill_op);
        end
    endtask

    task automatic test_tfault();
        do_reset();
        drive(SN'(3), 4'h1);
        checks++;
        if (con !== 12'h3E3) begin
            failures++;
            $display("FAIL tf_con got=%h exp=3e3", con);
        end
        tick();
        checks++;
        if (t_fault !== 1'b1) begin
            failures++;
            $display("FAIL tf_set got=%b exp=1", t_fault);
        end
        run_instr(4'h1, "tf_after");
        checks++;
        if (t_fault !== 1'b1) begin
            failures++;
            $display("FAIL tf_sticky got=%b exp=1", t_fault);
        end
    endtask

    task automatic test_random();
        logic [3:0]    op;
        logic [SN-1:0] s;
        logic [11:0]   exp;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 7) == 0) begin
                s = SN'($urandom_range(0, 63));
                drive(s, op);
                exp = ref_con(state, opcode, m_halted);
                checks++;
                if (con !== exp) begin
                    failures++;
                    $display("FAIL rand_glitch s=%b got=%h exp=%h", s, con, exp);
                end
                tick();
            end
            run_instr(op, "rand");
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_instr(4'h5, "ar_ill");
        for (int n = 0; n < 4; n++) run_instr(4'h1, "ar_add");
        for (int k = 0; k < 4; k++) begin
            drive(SN'(1) << k, 4'h1);
            tick();
        end
        drive(SN'(16), 4'h1);
        checks++;
`ifdef SEQ_INSTR_COUNT_EN
        if (instr_count !== CW'(5)) begin
            failures++;
            $display("FAIL ar_precount got=%0d exp=5", instr_count);
        end
`else
        if (instr_count !== CW'(0)) begin
            failures++;
            $display("FAIL ar_precount got=%0d exp=0", instr_count);
        end
`endif
        #1;
        CLR_bar = 1'b0;
        state = '0;
        #1;
        checks++;
        if ({HLT_bar, ill_op, t_fault, instr_count, con} !== {1'b1, 1'b0, 1'b0, CW'(0), 12'h3E3}) begin
            failures++;
            $display("FAIL ar_clear got=%b%b%b/%0d/%h exp=100/0/3e3", HLT_bar, ill_op, t_fault,
                     instr_count, con);
        end
        m_halted = 1'b0;
        m_ill = 1'b0;
        m_tf = 1'b0;
        m_cnt = '0;
        #1;
        CLR_bar = 1'b1;
    endtask

    initial begin
        m_halted = 1'b0;
        m_ill = 1'b0;
        m_tf = 1'b0;
        m_cnt = '0;
        test_reset();
        test_add();
        test_sub_out();
        test_hlt();
        test_ill();
        test_tfault();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Downstream consumer of the SAP-1 T-state ring counter. Decodes the one-hot T-state and the 4-bit instruction-register opcode into the 12-bit SAP-1 control word.
- Owns sequential status: a HLT latch that drives clock-stop, a sticky illegal-opcode flag, a sticky T-state-fault flag and an optional retired-instruction counter.
- Sits between the ring counter/IR and the datapath register enables.

Parameters:
- STATES, 6: width of the one-hot T-state bus; must be >= 6. Only T1..T6 decode; T7+ are idle.
- COUNT_WIDTH, 8: width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock. All sequential state updates on negedge, matching the ring counter.
- CLR_bar  input  1  asynchronous, active-low reset.
- state  input  STATES  one-hot T-state from the ring counter. Bit0 = T1. All-zero = cleared.
- opcode  input  4  IR upper nibble, stable from mid-T3.
- con  output  12  control word, MSB..LSB: Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar.
- HLT_bar  output  1  low once HLT has executed; gates the system clock.
- ill_op  output  1  sticky: undefined opcode reached T4.
- t_fault  output  1  sticky: state was non-zero and not one-hot.
- instr_count  output  COUNT_WIDTH  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (CLR_bar low, async):
  - halted=0, so HLT_bar=1.
  - ill_op=0, t_fault=0, instr_count=0.
- con is combinational from state, opcode and the registered flags. Zero latency.
- IDLE control word = 12'h3E3 (all active-low bits high). con=IDLE when any of:
  - state all-zero;
  - state not one-hot;
  - halted=1;
  - undecoded T-state.
- Fetch, opcode-independent:
  - T1=12'h5E3
  - T2=12'hBE3
  - T3=12'h263
- Execute:
  - LDA 0000: T4=12'h1A3, T5=12'h2C3, T6=IDLE.
  - ADD 0001: T4=12'h1A3, T5=12'h2E1, T6=12'h3C7.
  - SUB 0010: T4=12'h1A3, T5=12'h2E1, T6=12'h3CF.
  - OUT 1110: T4=12'h3F2, T5/T6=IDLE.
  - HLT 1111: T4..T6=IDLE.
  - Any other opcode: T4..T6=IDLE (treated as NOP).
- HLT latch:
  - Set on the negedge that leaves T4 when opcode==1111. HLT_bar falls at the start of T5.
  - Cleared only by CLR_bar.
  - While halted, con=IDLE regardless of state.
- ill_op: set on the negedge leaving T4 when the opcode is undefined. Sticky until reset.
- t_fault: set on any negedge where state!=0 and state is not one-hot (popcount>1). Sticky until reset.
- Simultaneous events: HLT and ill_op cannot both set. t_fault may set alongside either.
- Reset mid-instruction: all flags clear immediately. con follows the (cleared) state, giving IDLE.

Optional Feature:
- Macro: SEQ_INSTR_COUNT_EN.
- Defined:
  - instr_count increments on the negedge leaving T6 when halted=0 and t_fault=0.
  - Wraps modulo 2^COUNT_WIDTH.
  - HLT never counts, because halted is already set before T6.
- Undefined: instr_count tied to 0 and no counter flops are inferred. The port is still present.

Decomposition:
- Package sap1_ctrl_pkg holds:
  - opcode localparams OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - a packed struct ctrl_word_t in the bit order above;
  - CW_IDLE and the T1..T3 fetch constants.
- One sub-module, ctrl_decode: purely combinational (T-index, opcode) to ctrl_word_t.
- The top module holds the flags, the counter and the IDLE override.

Test Plan:
- Reset, then step T1..T6 with opcode=0001 -> con = 5E3, BE3, 263, 1A3, 2E1, 3C7. instr_count=1 after the T6 negedge.
- opcode=0010 through T6 -> T6 con=3CF. opcode=1110 -> T4 con=3F2, T5 con=3E3.
- opcode=1111 at T4 -> HLT_bar=1 during T4, 0 from T5. con=3E3 for all subsequent states. instr_count unchanged. CLR_bar pulse restores HLT_bar=1.
- opcode=0101 at T4 -> ill_op=1 after the T4 negedge, con=3E3 at T4..T6. ill_op stays 1 through the next instruction until reset.
- Force state=6'b000011 for one negedge -> t_fault=1, con=3E3 that cycle. Flag persists after a valid state resumes.
- Assert CLR_bar low asynchronously mid-T5 of ADD with count=5 -> instr_count=0, flags=0, con=3E3 immediately. Build without SEQ_INSTR_COUNT_EN -> instr_count always 0.
